// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: sole regfile write-port driver; merges ALU and long-latency writebacks, tracks busy registers.
// Rev 1.0
`default_nettype none

module rf_wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int REG_NUM    = 32,
  parameter int IDX_W      = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_wb_valid,
  input  logic [IDX_W-1:0] alu_wb_index,
  input  logic [XLEN-1:0]  alu_wb_data,
  input  logic             lsu_wb_valid,
  output logic             lsu_wb_ready,
  input  logic [IDX_W-1:0] lsu_wb_index,
  input  logic [XLEN-1:0]  lsu_wb_data,
  input  logic             issue_en,
  input  logic             issue_long,
  input  logic [IDX_W-1:0] issue_rd_index,
  input  logic [IDX_W-1:0] rs1_index,
  input  logic [IDX_W-1:0] rs2_index,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             wb_stall,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_index,
  output logic [XLEN-1:0]  rd_data
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_LAST = ST_W'(STARVE_MAX - 2);

  logic [IDX_W-1:0] fifo_idx [LQ_DEPTH];
  logic [XLEN-1:0]  fifo_dat [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             alu_sel;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             rd_from_fifo;

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic [ST_W-1:0]    starve_cnt;

  assign alu_sel      = alu_wb_valid && (alu_wb_index != '0);
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign lsu_wb_ready = !fifo_full;
  assign push         = lsu_wb_valid && !fifo_full && (lsu_wb_index != '0);
  assign pop          = !alu_sel && !fifo_empty;

  // Storage needs no reset: count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= lsu_wb_index;
      fifo_dat[wr_ptr] <= lsu_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en        <= 1'b0;
      rd_from_fifo <= 1'b0;
      rd_index     <= '0;
      rd_data      <= '0;
    end else begin
      rd_en        <= alu_sel || pop;
      rd_from_fifo <= pop;
      if (alu_sel) begin
        rd_index <= alu_wb_index;
        rd_data  <= alu_wb_data;
      end else if (pop) begin
        rd_index <= fifo_idx[rd_ptr];
        rd_data  <= fifo_dat[rd_ptr];
      end
    end
  end

  // Clear is applied before set so a newer producer of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (rd_en && rd_from_fifo) busy_nxt[rd_index] = 1'b0;
    if (issue_en && issue_long && (issue_rd_index != '0)) busy_nxt[issue_rd_index] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign rs1_busy = (rs1_index != '0) && busy[rs1_index];
  assign rs2_busy = (rs2_index != '0) && busy[rs2_index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      wb_stall <= 1'b0;
      if (!fifo_empty && !pop) begin
        if (starve_cnt == STARVE_LAST) begin
          wb_stall   <= 1'b1;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_cnt + ST_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter with a queue-based reference model.
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int XLEN = 64;
  localparam int IDXW = 5;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_wb_valid = 1'b0;
  logic [IDXW-1:0] alu_wb_index = '0;
  logic [XLEN-1:0] alu_wb_data = '0;
  logic            lsu_wb_valid = 1'b0;
  logic            lsu_wb_ready;
  logic [IDXW-1:0] lsu_wb_index = '0;
  logic [XLEN-1:0] lsu_wb_data = '0;
  logic            issue_en = 1'b0;
  logic            issue_long = 1'b0;
  logic [IDXW-1:0] issue_rd_index = '0;
  logic [IDXW-1:0] rs1_index = '0;
  logic [IDXW-1:0] rs2_index = '0;
  logic            rs1_busy, rs2_busy, wb_stall, rd_en;
  logic [IDXW-1:0] rd_index;
  logic [XLEN-1:0] rd_data;

  rf_wb_arbiter #(.XLEN(XLEN), .REG_NUM(32), .IDX_W(IDXW), .LQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_index(alu_wb_index), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_index(lsu_wb_index), .lsu_wb_data(lsu_wb_data),
    .issue_en(issue_en), .issue_long(issue_long), .issue_rd_index(issue_rd_index),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_stall(wb_stall), .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [IDXW-1:0] lq_idx[$];
  logic [XLEN-1:0] lq_dat[$];
  logic [IDXW-1:0] exp_idx[$];
  logic [XLEN-1:0] exp_dat[$];
  bit              mbusy[32];
  int              starved = 0;
  bit              mstall = 0;
  int              pend_clr = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    lq_idx.delete(); lq_dat.delete(); exp_idx.delete(); exp_dat.delete();
    foreach (mbusy[i]) mbusy[i] = 0;
    starved = 0; mstall = 0; pend_clr = 0;
  endtask

  // Monitor: every registered write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rd_en === 1'b1) begin
      if (exp_idx.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got x%0d=%0h expected none", rd_index, rd_data);
      end else begin
        chk("rd_index", XLEN'(rd_index), XLEN'(exp_idx.pop_front()));
        chk("rd_data", rd_data, exp_dat.pop_front());
      end
    end
  end

  task automatic step(input bit av, input logic [IDXW-1:0] ai, input logic [XLEN-1:0] ad,
                      input bit lv, input logic [IDXW-1:0] li, input logic [XLEN-1:0] ld,
                      input bit ie, input bit il, input logic [IDXW-1:0] ir,
                      input logic [IDXW-1:0] r1, input logic [IDXW-1:0] r2);
    bit rdy, had, popped;
    logic [IDXW-1:0] popped_idx;
    @(posedge clk); #1;
    // Bench honours the protocol: no ALU write during wb_stall or to a pending register.
    if (mstall || mbusy[ai]) av = 0;
    alu_wb_valid = av; alu_wb_index = ai; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_index = li; lsu_wb_data = ld;
    issue_en = ie; issue_long = il; issue_rd_index = ir;
    rs1_index = r1; rs2_index = r2;
    #1;
    rdy = (lq_idx.size() < DEPTH);
    chk("lsu_wb_ready", XLEN'(lsu_wb_ready), XLEN'(rdy));
    chk("rs1_busy", XLEN'(rs1_busy), XLEN'(mbusy[r1]));
    chk("rs2_busy", XLEN'(rs2_busy), XLEN'(mbusy[r2]));
    chk("wb_stall", XLEN'(wb_stall), XLEN'(mstall));
    had = (lq_idx.size() != 0);
    popped = 0; popped_idx = '0;
    if (av && ai != 0) begin
      exp_idx.push_back(ai); exp_dat.push_back(ad);
    end else if (had) begin
      popped = 1; popped_idx = lq_idx[0];
      exp_idx.push_back(lq_idx.pop_front()); exp_dat.push_back(lq_dat.pop_front());
    end
    if (lv && rdy && li != 0) begin
      lq_idx.push_back(li); lq_dat.push_back(ld);
    end
    if (pend_clr != 0) mbusy[pend_clr] = 0;
    if (ie && il && ir != 0) mbusy[ir] = 1;
    pend_clr = popped ? int'(popped_idx) : 0;
    mstall = 0;
    if (had && !popped) begin
      starved++;
      if (starved == SMAX - 1) begin
        mstall = 1; starved = 0;
      end
    end else begin
      starved = 0;
    end
  endtask

  task automatic idle(input logic [IDXW-1:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    alu_wb_valid = 0; lsu_wb_valid = 0; issue_en = 0; issue_long = 0;
    model_flush();
    #1;
    chk("rst_rd_en", XLEN'(rd_en), 0);
    chk("rst_ready", XLEN'(lsu_wb_ready), 1);
    chk("rst_stall", XLEN'(wb_stall), 0);
    for (int r = 1; r < 32; r++) begin
      rs1_index = IDXW'(r);
      #0.1;
      chk("rst_busy", XLEN'(rs1_busy), 0);
    end
    @(posedge clk); #3;
    rst_n = 1;
  endtask

  initial begin
    #1;
    chk("init_rd_en", XLEN'(rd_en), 0);
    chk("init_rd_index", XLEN'(rd_index), 0);
    chk("init_rd_data", rd_data, 0);
    chk("init_ready", XLEN'(lsu_wb_ready), 1);
    chk("init_stall", XLEN'(wb_stall), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    // ALU write x5
    step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);

    // Long-latency x7 with busy tracking
    step(0, 0, 0, 0, 0, 0, 1, 1, 7, 7, 0);
    idle(7); idle(7);
    step(0, 0, 0, 1, 7, 64'hDEAD, 0, 0, 0, 7, 0);
    repeat (4) idle(7);

    // ALU every cycle starves a single FIFO entry until wb_stall
    for (int i = 0; i < 12; i++)
      step(1, IDXW'(10 + i % 5), {$urandom, $urandom}, i == 0, 3, 64'hC0FFEE, 0, 0, 0, 3, 0);
    repeat (3) idle(0);

    // Fill FIFO while ALU is busy; extra pushes must be refused
    for (int i = 0; i < 6; i++)
      step(1, 20, {$urandom, $urandom}, 1, IDXW'(i + 1), 64'h100 + 64'(i), 0, 0, 0, 0, 0);
    repeat (6) idle(0);

    // Set wins over clear on the same register
    step(0, 0, 0, 1, 9, 64'h9999, 0, 0, 0, 9, 0);
    idle(9);
    step(0, 0, 0, 0, 0, 0, 1, 1, 9, 9, 0);
    idle(9); idle(9);

    // x0 writes are dropped on both paths
    step(1, 0, 64'h55, 1, 0, 64'h66, 0, 0, 0, 0, 0);
    idle(0); idle(0);

    // Reset with entries in flight
    step(0, 0, 0, 0, 0, 0, 1, 1, 12, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 21, {$urandom, $urandom}, 1, IDXW'(12 + i), {$urandom, $urandom}, 1, 1, IDXW'(13 + i), 12, 13);
    do_reset();
    idle(12); idle(13);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step($urandom_range(0, 1), IDXW'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 9) < 4), IDXW'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 9) < 3), $urandom_range(0, 1), IDXW'($urandom),
           IDXW'($urandom), IDXW'($urandom));
    end
    repeat (20) idle(0);
    @(posedge clk); #6;
    chk("leftover_writes", XLEN'(exp_idx.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
